hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Hazard and stall controller in the ID stage of the 5-stage RV32 pipeline. It sits directly upstream of the Control unit and drives that unit's NoOp input.
- Detects load-use hazards and inserts a bubble. Flushes IF/ID on taken branches.
- Freezes the whole pipeline while the L1 data cache reports a miss.
- Keeps saturating performance counters for bubbles, flushes, miss events and miss-stall cycles.

Parameters:
CNT_W, 32, width of each performance counter

Ports:
clk_i  input  1  pipeline clock
rst_i  input  1  synchronous, active-high reset
ID_op_i  input  7  opcode of instruction in ID
ID_rs1_i  input  5  rs1 field of instruction in ID
ID_rs2_i  input  5  rs2 field of instruction in ID
EX_MemRead_i  input  1  instruction in EX is a load
EX_rd_i  input  5  destination register of instruction in EX
branch_taken_i  input  1  branch in ID resolved taken this cycle
mem_stall_i  input  1  dcache busy (miss being serviced), level signal
PCWrite_o  output  1  PC update enable
IFIDWrite_o  output  1  IF/ID register write enable
IFIDFlush_o  output  1  IF/ID register clear
NoOp_o  output  1  to Control: zero all control outputs (bubble into ID/EX)
pipe_stall_o  output  1  freeze ID/EX, EX/MEM, MEM/WB registers
miss_done_o  output  1  one-cycle pulse in the first cycle after a miss stall ends
bubble_cnt_o  output  CNT_W  load-use bubbles inserted
flush_cnt_o  output  CNT_W  IF/ID flushes issued
miss_cnt_o  output  CNT_W  dcache miss events
miss_cyc_cnt_o  output  CNT_W  cycles spent in miss stall

Behaviour:
Interface:
- Single clock clk_i.
- rst_i is synchronous and active-high. All state updates on the rising edge of clk_i.

Operand use, decoded from ID_op_i:
- uses_rs1 = op in {0110011, 0010011, 0000011, 0100011, 1100011}.
- uses_rs2 = op in {0110011, 0100011, 1100011}.
- Any other opcode, including 0000000 (bubble), uses neither operand.

Hazard term:
- load_use = EX_MemRead_i and EX_rd_i != 0 and ((uses_rs1 and EX_rd_i == ID_rs1_i) or (uses_rs2 and EX_rd_i == ID_rs2_i)).

Output priority (combinational, same cycle):
1. rst_i = 1: PCWrite = 0, IFIDWrite = 0, IFIDFlush = 0, NoOp = 1, pipe_stall = 0.
2. mem_stall_i = 1: PCWrite = 0, IFIDWrite = 0, pipe_stall = 1, NoOp = 0, IFIDFlush = 0.
   - This is a freeze, not a bubble. Load-use and branch are ignored and re-evaluated after the stall.
3. load_use = 1: PCWrite = 0, IFIDWrite = 0, NoOp = 1, IFIDFlush = 0.
   - A taken branch that depends on the load is suppressed this cycle and re-resolved next cycle.
4. branch_taken_i = 1: IFIDFlush = 1, PCWrite = 1, IFIDWrite = 1, NoOp = 0.
5. Otherwise: PCWrite = 1, IFIDWrite = 1, all others 0.

FSM states:
- RUN: mem_stall_i = 1 moves to MEM_WAIT.
- MEM_WAIT: mem_stall_i = 0 moves to RUN; otherwise stays.
- miss_done_o is registered. It is 1 for exactly the one cycle after the MEM_WAIT→RUN transition; 0 otherwise, and 0 on reset.
- Back-to-back misses (mem_stall_i dropping for one cycle, then rising again):
  - Produce two miss events.
  - Produce a miss_done_o pulse coincident with the re-entry to MEM_WAIT.

Counters (registered):
- All counters reset to 0. Each saturates at all-ones: no wrap.
- bubble_cnt increments when priority 3 is active.
- flush_cnt increments when priority 4 is active.
- miss_cnt increments on the RUN→MEM_WAIT transition.
- miss_cyc_cnt increments on every cycle with mem_stall_i = 1.

Reset:
- Reset mid-miss forces state to RUN, clears counters and clears miss_done_o next edge.
- mem_stall_i is ignored while rst_i = 1.

Latency:
- All hazard outputs are zero-latency.
- Counters and miss_done_o reflect events one cycle later.

Decomposition:
- Shared package pipe_pkg holds:
  - Opcode constants OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH.
  - The 1-bit state encoding ST_RUN/ST_MEM_WAIT.
  - The same opcode constants are used by Control.
- One sub-module is natural: sat_counter (parameter W; inc, rst). Instantiated four times.
- Operand-use decode stays inline.

Test Plan:
- Load-use on rs1: EX_MemRead = 1, EX_rd = 5, ID_op = 0110011, rs1 = 5 -> PCWrite = 0, IFIDWrite = 0, NoOp = 1; bubble_cnt = 1 next cycle. Same with EX_rd = 0 -> no stall.
- rs2 not used: ID_op = 0010011, rs2 field = 5, EX_rd = 5, EX_MemRead = 1, rs1 = 6 -> no stall. ID_op = 0100011 with same fields -> stall.
- Branch vs load-use: branch_taken = 1 with load_use = 1 -> NoOp = 1, IFIDFlush = 0. Next cycle, load_use = 0 and branch_taken = 1 -> IFIDFlush = 1, flush_cnt = 1.
- Miss stall: mem_stall_i high for 4 cycles, with load_use and branch also asserted -> pipe_stall = 1, NoOp = 0, PCWrite = 0 for 4 cycles; miss_cnt = 1, miss_cyc_cnt = 4; miss_done_o pulses once in cycle 5.
- Reset mid-miss: assert rst_i in cycle 2 of a miss -> next edge counters = 0, state RUN; no miss_done_o pulse; NoOp = 1 while rst_i high.
- Saturation: CNT_W = 3, 9 consecutive load-use cycles -> bubble_cnt stops at 7.

Source files
------------

// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline package for the 5-stage RV32 core.
// It holds two things:
//   - the major opcode constants, which the Control unit also uses;
//   - the state encoding of the hazard/stall unit's miss FSM.
package pipe_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } hs_state_e;

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Bundle of signals between the ID-stage hazard/stall unit and the rest of
// the pipeline.
//   slave  : the hazard unit. It receives the ID/EX hazard fields and drives
//            the stall/flush controls and the performance counters.
//   master : the pipeline side. It drives the hazard fields and observes the
//            controls.
interface hazard_stall_unit_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       ID_op_i;
  logic [4:0]       ID_rs1_i;
  logic [4:0]       ID_rs2_i;
  logic             EX_MemRead_i;
  logic [4:0]       EX_rd_i;
  logic             branch_taken_i;
  logic             mem_stall_i;
  logic             PCWrite_o;
  logic             IFIDWrite_o;
  logic             IFIDFlush_o;
  logic             NoOp_o;
  logic             pipe_stall_o;
  logic             miss_done_o;
  logic [CNT_W-1:0] bubble_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;
  logic [CNT_W-1:0] miss_cnt_o;
  logic [CNT_W-1:0] miss_cyc_cnt_o;

  modport slave (
    input  ID_op_i, ID_rs1_i, ID_rs2_i, EX_MemRead_i, EX_rd_i,
           branch_taken_i, mem_stall_i,
    output PCWrite_o, IFIDWrite_o, IFIDFlush_o, NoOp_o, pipe_stall_o,
           miss_done_o, bubble_cnt_o, flush_cnt_o, miss_cnt_o, miss_cyc_cnt_o
  );

  modport master (
    output ID_op_i, ID_rs1_i, ID_rs2_i, EX_MemRead_i, EX_rd_i,
           branch_taken_i, mem_stall_i,
    input  PCWrite_o, IFIDWrite_o, IFIDFlush_o, NoOp_o, pipe_stall_o,
           miss_done_o, bubble_cnt_o, flush_cnt_o, miss_cnt_o, miss_cyc_cnt_o
  );
endinterface

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating up-counter used for the performance counters.
// Ports:
//   clk_i : clock
//   rst_i : synchronous, active-high clear
//   inc_i : count enable
//   cnt_o : current count; it holds at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard and stall controller.
// Behaviour:
//   - On a load-use hazard it inserts a bubble: PC and IF/ID are held and
//     NoOp is raised to the Control unit.
//   - On a taken branch it flushes IF/ID.
//   - While the dcache is servicing a miss it freezes the whole pipeline.
//   - It keeps saturating counters for bubbles, flushes, miss events and
//     miss-stall cycles.
// Ports:
//   clk_i, rst_i : clock and synchronous active-high reset
//   bus          : hazard inputs, pipeline controls and counters (slave side)
// Timing: the control outputs are combinational. miss_done_o and the
// counters are registered, so they show an event one cycle after it happens.
module hazard_stall_unit
  import pipe_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  hazard_stall_unit_if.slave  bus
);

  logic             uses_rs1;
  logic             uses_rs2;
  logic             load_use;
  logic             bubble_inc;
  logic             flush_inc;
  logic             miss_inc;
  logic             miss_cyc_inc;
  hs_state_e        state_d;
  hs_state_e        state_q;
  logic             miss_done_d;
  logic             miss_done_q;
  logic [CNT_W-1:0] bubble_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] miss_cnt;
  logic [CNT_W-1:0] miss_cyc_cnt;

  // Operand-use decode. An all-zero opcode is a bubble and reads nothing.
  assign uses_rs1 = bus.ID_op_i inside {OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH};
  assign uses_rs2 = bus.ID_op_i inside {OP_RTYPE, OP_STORE, OP_BRANCH};

  // x0 is never a real dependency, even when a load names it as rd.
  assign load_use = bus.EX_MemRead_i && (bus.EX_rd_i != 5'd0) &&
                    ((uses_rs1 && (bus.EX_rd_i == bus.ID_rs1_i)) ||
                     (uses_rs2 && (bus.EX_rd_i == bus.ID_rs2_i)));

  // Control outputs, in priority order.
  // A miss stall is a freeze, not a bubble: any hazard or branch seen during
  // it is simply re-evaluated once the stall lifts. A load-use hazard
  // suppresses a taken branch, because that branch may depend on the load
  // and has to be resolved again in the next cycle.
  always_comb begin
    bus.PCWrite_o    = 1'b1;
    bus.IFIDWrite_o  = 1'b1;
    bus.IFIDFlush_o  = 1'b0;
    bus.NoOp_o       = 1'b0;
    bus.pipe_stall_o = 1'b0;
    bubble_inc       = 1'b0;
    flush_inc        = 1'b0;
    if (rst_i) begin
      bus.PCWrite_o   = 1'b0;
      bus.IFIDWrite_o = 1'b0;
      bus.NoOp_o      = 1'b1;
    end else if (bus.mem_stall_i) begin
      bus.PCWrite_o    = 1'b0;
      bus.IFIDWrite_o  = 1'b0;
      bus.pipe_stall_o = 1'b1;
    end else if (load_use) begin
      bus.PCWrite_o   = 1'b0;
      bus.IFIDWrite_o = 1'b0;
      bus.NoOp_o      = 1'b1;
      bubble_inc      = 1'b1;
    end else if (bus.branch_taken_i) begin
      bus.IFIDFlush_o = 1'b1;
      flush_inc       = 1'b1;
    end
  end

  // Miss FSM. If the stall drops for a single cycle and then rises again,
  // the miss_done pulse lands on the same cycle that re-enters MEM_WAIT.
  always_comb begin
    state_d     = state_q;
    miss_done_d = 1'b0;
    miss_inc    = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (bus.mem_stall_i) begin
          state_d  = ST_MEM_WAIT;
          miss_inc = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (!bus.mem_stall_i) begin
          state_d     = ST_RUN;
          miss_done_d = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign miss_cyc_inc = bus.mem_stall_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_RUN;
      miss_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      miss_done_q <= miss_done_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk_i (clk_i), .rst_i (rst_i), .inc_i (bubble_inc),   .cnt_o (bubble_cnt)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i), .rst_i (rst_i), .inc_i (flush_inc),    .cnt_o (flush_cnt)
  );
  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk_i (clk_i), .rst_i (rst_i), .inc_i (miss_inc),     .cnt_o (miss_cnt)
  );
  sat_counter #(.W(CNT_W)) u_miss_cyc_cnt (
    .clk_i (clk_i), .rst_i (rst_i), .inc_i (miss_cyc_inc), .cnt_o (miss_cyc_cnt)
  );

  assign bus.miss_done_o    = miss_done_q;
  assign bus.bubble_cnt_o   = bubble_cnt;
  assign bus.flush_cnt_o    = flush_cnt;
  assign bus.miss_cnt_o     = miss_cnt;
  assign bus.miss_cyc_cnt_o = miss_cyc_cnt;

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_stall_unit_if #(.CNT_W(32)) ifa ();
  hazard_stall_unit_if #(.CNT_W(3))  ifs ();

  // Second, narrow-counter instance sees identical stimulus (saturation check).
  assign ifs.ID_op_i        = ifa.ID_op_i;
  assign ifs.ID_rs1_i       = ifa.ID_rs1_i;
  assign ifs.ID_rs2_i       = ifa.ID_rs2_i;
  assign ifs.EX_MemRead_i   = ifa.EX_MemRead_i;
  assign ifs.EX_rd_i        = ifa.EX_rd_i;
  assign ifs.branch_taken_i = ifa.branch_taken_i;
  assign ifs.mem_stall_i    = ifa.mem_stall_i;

  hazard_stall_unit #(.CNT_W(32)) dut   (.clk_i(clk), .rst_i(rst), .bus(ifa));
  hazard_stall_unit #(.CNT_W(3))  dut_s (.clk_i(clk), .rst_i(rst), .bus(ifs));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       mr;
    logic [4:0] rd;
    logic       br;
    logic       ms;
    logic [4:0] exp;  // {PCWrite, IFIDWrite, IFIDFlush, NoOp, pipe_stall}
  } vec_t;

  vec_t vecs[12];

  function automatic logic [4:0] ctl();
    return {ifa.PCWrite_o, ifa.IFIDWrite_o, ifa.IFIDFlush_o, ifa.NoOp_o, ifa.pipe_stall_o};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic mr, input logic [4:0] rd, input logic br, input logic ms);
    ifa.ID_op_i        = op;
    ifa.ID_rs1_i       = rs1;
    ifa.ID_rs2_i       = rs2;
    ifa.EX_MemRead_i   = mr;
    ifa.EX_rd_i        = rd;
    ifa.branch_taken_i = br;
    ifa.mem_stall_i    = ms;
  endtask

  task automatic idle();
    drive(7'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{"lu_rs1",       OP_RTYPE,  5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 5'b00010};
    vecs[1]  = '{"rd_x0",        OP_RTYPE,  5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 5'b11000};
    vecs[2]  = '{"itype_no_rs2", OP_ITYPE,  5'd6, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 5'b11000};
    vecs[3]  = '{"store_rs2",    OP_STORE,  5'd6, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 5'b00010};
    vecs[4]  = '{"br_vs_lu",     OP_BRANCH, 5'd1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 5'b00010};
    vecs[5]  = '{"br_taken",     OP_BRANCH, 5'd1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 5'b11100};
    vecs[6]  = '{"no_memread",   OP_RTYPE,  5'd5, 5'd5, 1'b0, 5'd5, 1'b0, 1'b0, 5'b11000};
    vecs[7]  = '{"bubble_op",    7'd0,      5'd5, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 5'b11000};
    vecs[8]  = '{"load_rs1",     OP_LOAD,   5'd5, 5'd1, 1'b1, 5'd5, 1'b0, 1'b0, 5'b00010};
    vecs[9]  = '{"load_no_rs2",  OP_LOAD,   5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 5'b11000};
    vecs[10] = '{"miss_freeze",  OP_RTYPE,  5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 5'b00001};
    vecs[11] = '{"lui_no_ops",   7'b0110111,5'd5, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 5'b11000};

    // Reset: priority over a concurrent miss and hazard
    rst = 1'b1;
    drive(OP_RTYPE, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1);
    @(negedge clk);
    chk("rst_ctl", {27'd0, ctl()}, 32'b00010);
    tick();
    @(negedge clk);
    chk("rst_ctl2", {27'd0, ctl()}, 32'b00010);
    tick();
    rst = 1'b0;
    idle();
    @(negedge clk);
    chk("rst_bubble", ifa.bubble_cnt_o, 0);
    chk("rst_flush", ifa.flush_cnt_o, 0);
    chk("rst_miss", ifa.miss_cnt_o, 0);
    chk("rst_miss_cyc", ifa.miss_cyc_cnt_o, 0);
    chk("rst_miss_done", {31'd0, ifa.miss_done_o}, 0);
    tick();

    // Combinational vector table
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].mr, vecs[i].rd, vecs[i].br, vecs[i].ms);
      @(negedge clk);
      chk(vecs[i].name, {27'd0, ctl()}, {27'd0, vecs[i].exp});
      tick();
    end
    idle();
    tick();
    do_reset();

    // Load-use bubble is counted one cycle later
    drive(OP_RTYPE, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0);
    @(negedge clk);
    chk("lu_bubble_cnt_before", ifa.bubble_cnt_o, 0);
    tick();
    idle();
    @(negedge clk);
    chk("lu_bubble_cnt", ifa.bubble_cnt_o, 1);
    tick();
    do_reset();

    // Branch suppressed by load-use, then re-resolved
    drive(OP_BRANCH, 5'd5, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
    @(negedge clk);
    chk("brlu_c1", {27'd0, ctl()}, 32'b00010);
    tick();
    drive(OP_BRANCH, 5'd5, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("brlu_c2", {27'd0, ctl()}, 32'b11100);
    tick();
    idle();
    @(negedge clk);
    chk("brlu_flush_cnt", ifa.flush_cnt_o, 1);
    chk("brlu_bubble_cnt", ifa.bubble_cnt_o, 1);
    tick();
    do_reset();

    // Four-cycle miss with load-use and branch asserted
    for (int c = 0; c < 4; c++) begin
      drive(OP_RTYPE, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1);
      @(negedge clk);
      chk($sformatf("miss_ctl_c%0d", c), {27'd0, ctl()}, 32'b00001);
      chk($sformatf("miss_done_c%0d", c), {31'd0, ifa.miss_done_o}, 0);
      tick();
    end
    idle();
    @(negedge clk);
    chk("miss_cnt", ifa.miss_cnt_o, 1);
    chk("miss_cyc_cnt", ifa.miss_cyc_cnt_o, 4);
    chk("miss_done_early", {31'd0, ifa.miss_done_o}, 0);
    chk("miss_no_bubble", ifa.bubble_cnt_o, 0);
    chk("miss_no_flush", ifa.flush_cnt_o, 0);
    tick();
    @(negedge clk);
    chk("miss_done_pulse", {31'd0, ifa.miss_done_o}, 1);
    tick();
    @(negedge clk);
    chk("miss_done_end", {31'd0, ifa.miss_done_o}, 0);
    tick();
    do_reset();

    // Back-to-back misses: high 2, low 1, high 2, low
    drive(7'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1); tick();
    tick();
    idle(); tick();
    drive(7'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk("b2b_done_on_reentry", {31'd0, ifa.miss_done_o}, 1);
    chk("b2b_miss_cnt_mid", ifa.miss_cnt_o, 1);
    tick();
    @(negedge clk);
    chk("b2b_done_clear", {31'd0, ifa.miss_done_o}, 0);
    tick();
    idle(); tick();
    @(negedge clk);
    chk("b2b_miss_cnt", ifa.miss_cnt_o, 2);
    chk("b2b_miss_cyc", ifa.miss_cyc_cnt_o, 4);
    chk("b2b_done_final", {31'd0, ifa.miss_done_o}, 1);
    tick();
    do_reset();

    // Reset in the second cycle of a miss
    drive(7'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1); tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rstmiss_ctl", {27'd0, ctl()}, 32'b00010);
    tick();
    rst = 1'b0;
    idle();
    @(negedge clk);
    chk("rstmiss_miss_cnt", ifa.miss_cnt_o, 0);
    chk("rstmiss_miss_cyc", ifa.miss_cyc_cnt_o, 0);
    chk("rstmiss_done", {31'd0, ifa.miss_done_o}, 0);
    tick();
    @(negedge clk);
    chk("rstmiss_no_pulse", {31'd0, ifa.miss_done_o}, 0);
    chk("rstmiss_ctl_run", {27'd0, ctl()}, 32'b11000);
    tick();
    do_reset();

    // Saturation: 9 load-use cycles
    for (int c = 0; c < 9; c++) begin
      drive(OP_RTYPE, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0);
      tick();
    end
    idle();
    @(negedge clk);
    chk("sat_bubble_w3", {29'd0, ifs.bubble_cnt_o}, 7);
    chk("sat_bubble_w32", ifa.bubble_cnt_o, 9);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
